param_mem_slave: RTL and testbench
==================================

PARAM_MEM_SLAVE -- requirements
Module: param_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, external bus word-address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width; legal values 8, 16, 32.
REQ-003 SHALL have parameter DEPTH_LOG2, default 12, log2 of implemented words; DEPTH_LOG2 <= ADDR_W.
REQ-004 SHALL have parameter PROT_BASE, default 2**DEPTH_LOG2, first word address of the write-protected region.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have ports: cs  in  1  chip select; rd  in  1  read request; wr  in  1  write request.
REQ-008 SHALL have ports: addr  in  ADDR_W  word address; wdata  in  DATA_W  write data; be  in  DATA_W/8  byte-lane enables.
REQ-009 SHALL have ports: wait_cfg  in  4  wait states for the next accepted access, 0..15.
REQ-010 SHALL have ports: rdata  out  DATA_W  read data; ready  out  1  completion pulse; err  out  1  error flag, valid with ready; busy  out  1  access in progress.

Function
REQ-011 SHALL implement FSM IDLE, WAIT, RESP; accept only in IDLE when cs=1 and (rd or wr).
REQ-012 SHALL latch addr, wdata, be, rd, wr and wait_cfg on accept; later input changes SHALL not affect the access.
REQ-013 SHALL transition IDLE->WAIT on accept when the latched wait_cfg > 0, else IDLE->RESP; WAIT counts down the latched value and moves to RESP after exactly wait_cfg cycles.
REQ-014 SHALL assert ready for exactly one cycle in RESP, i.e. wait_cfg+1 cycles after the accept edge; RESP->IDLE unconditionally.
REQ-015 SHALL hold busy=1 in WAIT and RESP, 0 in IDLE; requests seen while busy=1 SHALL be ignored and not queued.
REQ-016 SHALL write, on a valid write, only the byte lanes with be[i]=1 at the RESP edge; other lanes unchanged.
REQ-017 SHALL update rdata with the full word on a valid read in the same cycle ready is asserted; rdata SHALL hold its value until the next read completion.
REQ-018 SHALL flag err=1 with ready, with no memory write and rdata forced to 0, when any of: rd and wr both 1 at accept; addr >= 2**DEPTH_LOG2; write with addr >= PROT_BASE.
REQ-019 SHALL treat a write with be all zero as a valid completion (ready=1, err=0) with no memory change.
REQ-020 SHALL allow a new accept in the cycle after RESP at the earliest (minimum 2 cycles per access at wait_cfg=0).
REQ-021 SHALL leave err=0 whenever ready=0.

Reset
REQ-022 SHALL, while rst_n=0 at a clock edge, force state IDLE, ready=0, err=0, busy=0, rdata=0, and clear the wait counter.
REQ-023 SHALL abort an in-flight access when reset occurs mid-access: no ready pulse, no memory write.
REQ-024 SHALL not initialise memory contents on reset; contents persist across reset.

Verification
REQ-025 SHALL cover, DATA_W=16, wait_cfg=0: write 0x1234 be=11 to 0x0010, then read 0x0010 -> ready 1 cycle after each accept, rdata=0x1234, err=0.
REQ-026 SHALL cover a byte-lane write: with 0x1234 at 0x0010, write 0xABCD be=01 -> read returns 0x12CD.
REQ-027 SHALL cover wait_cfg=5 read, then wait_cfg changed to 0 during WAIT -> ready exactly 6 cycles after accept, busy high for 6 cycles, second cs pulse during busy ignored.
REQ-028 SHALL cover errors: rd=wr=1; read addr 0x1000 with DEPTH_LOG2=12; write at PROT_BASE=0x0800 -> each gives ready=1, err=1, rdata=0x0000, memory unchanged.
REQ-029 SHALL cover reset: rst_n low during WAIT of a wait_cfg=8 write to 0x0020 -> no ready, busy=0 next cycle, 0x0020 keeps its prior value.
REQ-030 SHALL cover back-to-back: cs held high with rd=1, wait_cfg=0 -> one completion every 2 cycles, ready never high in consecutive cycles.

Source files
------------

// File: rtl/param_mem_slave.sv
// Parameterised single-port memory slave with programmable wait states.
// Each accepted request is captured, optionally delayed by a wait-state
// countdown, and completed with a one-cycle ready pulse. Accesses that
// use illegal commands, fall outside the implemented depth, or write into
// the protected region complete with err=1.
module param_mem_slave #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 12,
  parameter int PROT_BASE  = 2**DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cs,
  input  logic                rd,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  input  logic [3:0]          wait_cfg,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  output logic                err,
  output logic                busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CMP_W  = ADDR_W + 1;
  // One extra bit so a protection base equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] PROT_BASE_W = CMP_W'(PROT_BASE);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state;
  logic [3:0]          cnt;

  // Request captured at accept; holds the access stable while waiting.
  logic [ADDR_W-1:0]   addr_p0;
  logic [DATA_W-1:0]   wdata_p0;
  logic [NBYTES-1:0]   be_p0;
  logic                rd_p0;
  logic                wr_p0;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                complete;
  logic                use_live;
  logic [ADDR_W-1:0]   c_addr;
  logic [DATA_W-1:0]   c_wdata;
  logic [NBYTES-1:0]   c_be;
  logic                c_rd;
  logic                c_wr;
  logic                c_err;
  logic                do_write;
  logic [DEPTH_LOG2-1:0] idx;

  // Error classification for an access about to complete.
  function automatic logic access_err(input logic r, input logic w,
                                      input logic [ADDR_W-1:0] a);
    logic both;
    logic oor;
    logic prot;
    both = r && w;
    oor  = ((a >> DEPTH_LOG2) != '0);
    prot = w && ({1'b0, a} >= PROT_BASE_W);
    return both || oor || prot;
  endfunction

  // With zero wait states the access completes on the accept edge itself,
  // so the live inputs are used there; otherwise the captured copy is used.
  always_comb begin
    accept   = (state == S_IDLE) && cs && (rd || wr);
    use_live = (state == S_IDLE);
    c_addr   = use_live ? addr  : addr_p0;
    c_wdata  = use_live ? wdata : wdata_p0;
    c_be     = use_live ? be    : be_p0;
    c_rd     = use_live ? rd    : rd_p0;
    c_wr     = use_live ? wr    : wr_p0;
    complete = (accept && (wait_cfg == 4'd0)) ||
               ((state == S_WAIT) && (cnt == 4'd1));
    c_err    = access_err(c_rd, c_wr, c_addr);
    do_write = rst_n && complete && c_wr && !c_err;
    idx      = c_addr[DEPTH_LOG2-1:0];
  end

  // Control FSM: sequencing, wait countdown and registered response outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      busy  <= 1'b0;
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (accept) begin
            busy <= 1'b1;
            if (wait_cfg == 4'd0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= wait_cfg;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state <= S_RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
          err   <= 1'b0;
        end
      endcase
      // Completion: response is presented during the RESP cycle.
      if (complete) begin
        ready <= 1'b1;
        err   <= c_err;
        if (c_err) begin
          rdata <= '0;
        end else if (c_rd) begin
          rdata <= mem[idx];
        end
      end
    end
  end

  // Capture the request on accept; later input changes do not affect it.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= addr;
      wdata_p0 <= wdata;
      be_p0    <= be;
      rd_p0    <= rd;
      wr_p0    <= wr;
    end
  end

  // Byte-lane write into the array; contents are never reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (c_be[i]) begin
          mem[idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_param_mem_slave.sv
// Directed bench for param_mem_slave (16-bit data, 4K words, protected from 0x0800).
module tb_param_mem_slave;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [1:0]  be;
  logic [3:0]  wait_cfg;
  logic [15:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;

  int vecs;
  int miscompares;

  param_mem_slave #(
    .ADDR_W    (16),
    .DATA_W    (16),
    .DEPTH_LOG2(12),
    .PROT_BASE (16'h0800)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cs      (cs),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .be      (be),
    .wait_cfg(wait_cfg),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete access; returns cycles from accept edge to ready (capped).
  task automatic access(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] b, input logic [3:0] wc,
                        output int lat, output logic e, output logic [15:0] q);
    cs = 1'b1; rd = r; wr = w; addr = a; wdata = d; be = b; wait_cfg = wc;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    lat = 1;
    while (!ready && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e = err;
    q = rdata;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input string tag, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] b);
    int lat; logic e; logic [15:0] q;
    access(1'b0, 1'b1, a, d, b, 4'd0, lat, e, q);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_err"}, e, 0);
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [15:0] exp);
    int lat; logic e; logic [15:0] q;
    access(1'b1, 1'b0, a, 16'h0000, 2'b00, 4'd0, lat, e, q);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_err"}, e, 0);
    chk({tag, "_data"}, q, exp);
  endtask

  task automatic do_bad(input string tag, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
    int lat; logic e; logic [15:0] q;
    access(r, w, a, d, 2'b11, 4'd0, lat, e, q);
    chk({tag, "_lat"}, lat, 1);
    chk({tag, "_err"}, e, 1);
    chk({tag, "_data"}, q, 0);
  endtask

  initial begin
    int nready;
    vecs = 0; miscompares = 0;
    rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    addr = '0; wdata = '0; be = '0; wait_cfg = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-word write and readback, then a low-lane-only write.
    do_write("wr1234", 16'h0010, 16'h1234, 2'b11);
    do_read("rd1234", 16'h0010, 16'h1234);
    do_write("wrlane", 16'h0010, 16'hABCD, 2'b01);
    do_read("rdlane", 16'h0010, 16'h12CD);
    do_write("wrhi", 16'h0030, 16'h5A00, 2'b10);
    do_write("wrlo", 16'h0030, 16'hFF5A, 2'b01);

    // Wait-state read; wait_cfg change and a cs pulse during busy are ignored.
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h0030; wait_cfg = 4'd5;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0; wait_cfg = 4'd0; addr = 16'h0010;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("ws_busy%0d", k), busy, (k <= 6) ? 1 : 0);
      chk($sformatf("ws_ready%0d", k), ready, (k == 6) ? 1 : 0);
      if (k == 6) chk("ws_data", rdata, 16'h5A5A);
      if (k == 3) begin cs = 1'b1; rd = 1'b1; end
      if (k == 4) begin cs = 1'b0; rd = 1'b0; end
      @(posedge clk); #1;
    end

    // Error completions leave memory untouched.
    do_bad("err_rdwr", 1'b1, 1'b1, 16'h0010, 16'h0000);
    do_bad("err_oor", 1'b1, 1'b0, 16'h1000, 16'h0000);
    do_bad("err_prot", 1'b0, 1'b1, 16'h0800, 16'hFFFF);
    do_bad("err_alias", 1'b0, 1'b1, 16'h1010, 16'hFFFF);
    do_read("rd_after_err", 16'h0010, 16'h12CD);

    // Empty byte-enable write: clean completion, no change.
    do_write("wr_be0", 16'h0010, 16'h0000, 2'b00);
    do_read("rd_after_be0", 16'h0010, 16'h12CD);

    // Reset during a long-wait write aborts it.
    do_write("wr20", 16'h0020, 16'h1111, 2'b11);
    do_read("rd_pre_rst", 16'h0010, 16'h12CD);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 16'h0020; wdata = 16'h2222; be = 2'b11;
    wait_cfg = 4'd8;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy_pre", busy, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_ready", ready, 0);
    chk("abort_rdata", rdata, 0);
    rst_n = 1'b1;
    nready = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (ready) nready++;
    end
    chk("abort_no_ready", nready, 0);
    do_read("rd20", 16'h0020, 16'h1111);

    // Back-to-back reads with cs held high.
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h0010; wait_cfg = 4'd0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("b2b_ready%0d", k), ready, (k % 2 == 1) ? 1 : 0);
      if (k % 2 == 1) chk($sformatf("b2b_data%0d", k), rdata, 16'h12CD);
    end
    cs = 1'b0; rd = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("end_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
